// File: rtl/gb_trace_buffer.sv
//==============================================================================
// Module   : gb_trace_buffer
// Brief    : GameBoy instruction-trace capture into a circular buffer with
//            programmable trigger, post-trigger depth and ready/valid readout.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module gb_trace_buffer #(
    parameter  int DEPTH  = 64,
    parameter  int CYC_W  = 32,
    parameter  int POST_W = 8,
    localparam int ENT_W  = CYC_W + 28,
    localparam int FILL_W = $clog2(DEPTH) + 1
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       pc,
    input  logic [7:0]        ir,
    input  logic [3:0]        flags,
    input  logic              arm,
    input  logic              abort,
    input  logic [1:0]        trig_mode,
    input  logic [15:0]       trig_pc,
    input  logic [7:0]        trig_ir,
    input  logic [POST_W-1:0] post_cnt,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ENT_W-1:0]  rd_data,
    output logic [1:0]        state,
    output logic              triggered,
    output logic [FILL_W-1:0] fill
);

    localparam int C_AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CYC_W-1:0]    r_cyc;
    logic [C_AW-1:0]     r_wr_ptr;
    logic [FILL_W-1:0]   r_fill;
    logic [POST_W-1:0]   r_rem;
    logic [POST_W-1:0]   r_post;
    logic [1:0]          r_mode;
    logic [15:0]         r_tpc;
    logic [7:0]          r_tir;
    logic                r_trig;
    logic                r_rd_valid;
    logic [ENT_W-1:0]    r_rd_data;
    logic [ENT_W-1:0]    r_mem [DEPTH];

    logic                w_capture;
    logic                w_hit;
    logic                w_xfer;
    logic [FILL_W-1:0]   w_fill_inc;
    logic [FILL_W-1:0]   w_fill_dn;
    logic [C_AW-1:0]     w_rd_ptr;

    assign w_capture  = instr_valid && !abort && (r_state == S_ARMED || r_state == S_POST);
    assign w_fill_inc = (r_fill == FILL_W'(DEPTH)) ? r_fill : r_fill + 1'b1;
    assign w_xfer     = r_rd_valid && rd_ready;
    assign w_fill_dn  = r_fill - {{(FILL_W-1){1'b0}}, w_xfer};
    // The oldest unread entry always sits fill slots behind the write pointer.
    assign w_rd_ptr   = r_wr_ptr - w_fill_dn[C_AW-1:0];

    always_comb begin
        w_hit = 1'b0;
        case (r_mode)
            2'd0:    w_hit = 1'b1;
            2'd1:    w_hit = (pc == r_tpc);
            2'd2:    w_hit = (ir == r_tir);
            default: w_hit = 1'b0;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr] <= {r_cyc, pc, ir, flags};
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cyc      <= '0;
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_rem      <= '0;
            r_post     <= '0;
            r_mode     <= 2'd0;
            r_tpc      <= '0;
            r_tir      <= '0;
            r_trig     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_cyc <= r_cyc + 1'b1;
            if (abort) begin
                r_state    <= S_IDLE;
                r_fill     <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (arm) begin
                            r_state    <= S_ARMED;
                            r_fill     <= '0;
                            r_wr_ptr   <= '0;
                            r_trig     <= 1'b0;
                            r_rd_valid <= 1'b0;
                            r_mode     <= trig_mode;
                            r_tpc      <= trig_pc;
                            r_tir      <= trig_ir;
                            r_post     <= post_cnt;
                        end
                    end
                    S_ARMED: begin
                        if (instr_valid) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_fill   <= w_fill_inc;
                            if (w_hit) begin
                                r_trig  <= 1'b1;
                                r_rem   <= r_post;
                                r_state <= (r_post == '0) ? S_DONE : S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (instr_valid) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_fill   <= w_fill_inc;
                            r_rem    <= r_rem - 1'b1;
                            if (r_rem == POST_W'(1)) begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                    default: begin
                        if (arm) begin
                            r_state    <= S_ARMED;
                            r_fill     <= '0;
                            r_wr_ptr   <= '0;
                            r_trig     <= 1'b0;
                            r_rd_valid <= 1'b0;
                            r_mode     <= trig_mode;
                            r_tpc      <= trig_pc;
                            r_tir      <= trig_ir;
                            r_post     <= post_cnt;
                        end else begin
                            r_fill     <= w_fill_dn;
                            r_rd_valid <= (w_fill_dn != '0);
                            // Load a new head only when the register is empty or being consumed.
                            if ((w_fill_dn != '0) && (!r_rd_valid || w_xfer)) begin
                                r_rd_data <= r_mem[w_rd_ptr];
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign state     = r_state;
    assign triggered = r_trig;
    assign fill      = r_fill;

endmodule

`default_nettype wire

// File: tb/tb_gb_trace_buffer.sv
//==============================================================================
// Module   : tb_gb_trace_buffer
// Brief    : Randomized self-checking bench for gb_trace_buffer against a
//            queue-based reference model of the capture/readout rules.
// Revision : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gb_trace_buffer;

    localparam int DEPTH  = 8;
    localparam int CYC_W  = 32;
    localparam int POST_W = 8;
    localparam int ENT_W  = CYC_W + 28;

    logic              cpu_clk = 1'b0;
    logic              rst = 1'b1;
    logic              instr_valid = 1'b0;
    logic [15:0]       pc = '0;
    logic [7:0]        ir = '0;
    logic [3:0]        flags = '0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        trig_mode = '0;
    logic [15:0]       trig_pc = '0;
    logic [7:0]        trig_ir = '0;
    logic [POST_W-1:0] post_cnt = '0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [ENT_W-1:0]  rd_data;
    logic [1:0]        state;
    logic              triggered;
    logic [3:0]        fill;

    always #5 cpu_clk = ~cpu_clk;

    gb_trace_buffer #(.DEPTH(DEPTH), .CYC_W(CYC_W), .POST_W(POST_W)) u_dut (
        .cpu_clk(cpu_clk), .rst(rst), .instr_valid(instr_valid), .pc(pc), .ir(ir),
        .flags(flags), .arm(arm), .abort(abort), .trig_mode(trig_mode),
        .trig_pc(trig_pc), .trig_ir(trig_ir), .post_cnt(post_cnt),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .state(state), .triggered(triggered), .fill(fill)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the captured trace is a bounded queue, oldest first.
    logic [ENT_W-1:0] m_q[$];
    int               m_state;
    bit               m_trig;
    bit               m_rdv;
    int               m_rem;
    int               m_post;
    int               m_mode;
    logic [15:0]      m_tpc;
    logic [7:0]       m_tir;
    logic [CYC_W-1:0] m_cyc;

    task automatic model_arm();
        m_state = 1;
        m_q.delete();
        m_trig = 0;
        m_mode = int'(trig_mode);
        m_tpc  = trig_pc;
        m_tir  = trig_ir;
        m_post = int'(post_cnt);
    endtask

    // Advance the model by the inputs currently driven, then clock the DUT.
    task automatic step();
        bit               nxt_rdv;
        bit               hit;
        logic [ENT_W-1:0] ent;
        nxt_rdv = 0;
        ent = {m_cyc, pc, ir, flags};
        if (abort) begin
            m_state = 0;
            m_q.delete();
        end else begin
            case (m_state)
                0: if (arm) model_arm();
                1, 2: begin
                    if (instr_valid) begin
                        m_q.push_back(ent);
                        if (m_q.size() > DEPTH) void'(m_q.pop_front());
                        if (m_state == 1) begin
                            hit = (m_mode == 0) || (m_mode == 1 && pc == m_tpc) ||
                                  (m_mode == 2 && ir == m_tir);
                            if (hit) begin
                                m_trig  = 1;
                                m_rem   = m_post;
                                m_state = (m_post == 0) ? 3 : 2;
                            end
                        end else begin
                            m_rem--;
                            if (m_rem == 0) m_state = 3;
                        end
                    end
                end
                default: begin
                    if (arm) model_arm();
                    else begin
                        if (m_rdv && rd_ready) void'(m_q.pop_front());
                        nxt_rdv = (m_q.size() > 0);
                    end
                end
            endcase
        end
        m_rdv = nxt_rdv;
        m_cyc = m_cyc + 1;
        @(posedge cpu_clk);
        #1;
        instr_valid = 1'b0;
        arm         = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic instr(input logic [15:0] p, input logic [7:0] i);
        pc = p;
        ir = i;
        flags = 4'($urandom);
        instr_valid = 1'b1;
        step();
        repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge cpu_clk);
        #1;
        rst = 1'b0;
        m_q.delete(); m_state = 0; m_trig = 0; m_rdv = 0; m_cyc = '0; m_rem = 0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (fill !== 4'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered got %b exp 0", triggered); end
        for (int k = 0; k < 5; k++) begin
            instr(16'h0200 + 16'(k), 8'h00);
            checks++; if (fill !== 4'd0 || state !== 2'd0) begin
                errors++; $display("FAIL idle_ignore fill=%0d state=%0d exp 0/0", fill, state);
            end
        end
    endtask

    task automatic test_immediate();
        logic [31:0] prev;
        bit          first;
        rd_ready = 0; trig_mode = 2'd0; post_cnt = 8'd3;
        arm = 1; pc = 16'h00FF; instr_valid = 1;    // sample in the arming cycle is dropped
        step();
        for (int k = 0; k < 6; k++) begin
            instr(16'h0100 + 16'(k), 8'h00);
            checks++; if (state !== 2'(m_state) || fill !== 4'(m_q.size())) begin
                errors++; $display("FAIL imm_capture k=%0d state=%0d fill=%0d exp %0d/%0d", k, state, fill, m_state, m_q.size());
            end
            if (k == 3) begin
                checks++; if (state !== 2'd3 || fill !== 4'd4) begin
                    errors++; $display("FAIL imm_done state=%0d fill=%0d exp 3/4", state, fill);
                end
            end
        end
        rd_ready = 1; first = 1; prev = '0;
        for (int c = 0; c < 40 && (m_q.size() > 0 || m_rdv); c++) begin
            checks++; if (rd_valid !== m_rdv) begin errors++; $display("FAIL imm_rd_valid got %b exp %b", rd_valid, m_rdv); end
            if (m_rdv) begin
                checks++; if (rd_data !== m_q[0]) begin errors++; $display("FAIL imm_rd_data got %h exp %h", rd_data, m_q[0]); end
                checks++; if (!first && rd_data[59:28] <= prev) begin
                    errors++; $display("FAIL imm_stamp_order got %0d prev %0d", rd_data[59:28], prev);
                end
                prev = rd_data[59:28]; first = 0;
            end
            step();
        end
        checks++; if (fill !== 4'd0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL imm_drained fill=%0d rd_valid=%b exp 0/0", fill, rd_valid);
        end
    endtask

    task automatic test_pc_match();
        logic [3:0] pat;
        int         n;
        pat = 4'b1001;
        rd_ready = 0; trig_mode = 2'd1; trig_pc = 16'h0150; post_cnt = 8'd2;
        arm = 1; step();
        trig_pc = 16'h0141;    // must be ignored until the next arm
        for (int k = 0; k < 20; k++) instr(16'h0140 + 16'(k), 8'(k));
        checks++; if (triggered !== 1'b1 || state !== 2'd3 || fill !== 4'd8) begin
            errors++; $display("FAIL pc_capture trig=%b state=%0d fill=%0d exp 1/3/8", triggered, state, fill);
        end
        n = 0;
        for (int c = 0; c < 60 && (m_q.size() > 0 || m_rdv); c++) begin
            rd_ready = pat[c % 4];
            checks++; if (rd_valid !== m_rdv) begin errors++; $display("FAIL pc_rd_valid got %b exp %b", rd_valid, m_rdv); end
            if (m_rdv) begin
                checks++; if (rd_data !== m_q[0]) begin errors++; $display("FAIL pc_rd_data got %h exp %h", rd_data, m_q[0]); end
                if (n == 0) begin
                    checks++; if (rd_data[27:12] !== 16'h014B) begin
                        errors++; $display("FAIL pc_oldest got %h exp 014b", rd_data[27:12]);
                    end
                end
                if (rd_ready) n++;
            end
            step();
            checks++; if (fill !== 4'(m_q.size())) begin errors++; $display("FAIL pc_fill got %0d exp %0d", fill, m_q.size()); end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL pc_count got %0d exp 8", n); end
    endtask

    task automatic test_ir_never();
        rd_ready = 0; trig_mode = 2'd2; trig_ir = 8'h76; post_cnt = 8'd1;
        arm = 1; step();
        for (int k = 0; k < 12; k++) instr(16'h0300 + 16'(k), 8'($urandom_range(0, 8'h75)));
        checks++; if (state !== 2'd1 || fill !== 4'd8 || triggered !== 1'b0) begin
            errors++; $display("FAIL ir_armed state=%0d fill=%0d trig=%b exp 1/8/0", state, fill, triggered);
        end
        abort = 1; step();
        checks++; if (state !== 2'd0 || fill !== 4'd0) begin
            errors++; $display("FAIL ir_abort state=%0d fill=%0d exp 0/0", state, fill);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        rd_ready = 0; trig_mode = 2'd0; post_cnt = 8'd7;
        arm = 1; step();
        for (int k = 0; k < 8; k++) instr(16'h0400 + 16'(k), 8'hA0);
        step();
        checks++; if (rd_valid !== 1'b1 || fill !== 4'd8) begin
            errors++; $display("FAIL b2b_ready rd_valid=%b fill=%0d exp 1/8", rd_valid, fill);
        end
        rd_ready = 1; cyc = 0;
        while (rd_valid === 1'b1 && cyc < 20) begin
            checks++; if (rd_data !== m_q[0]) begin errors++; $display("FAIL b2b_rd_data got %h exp %h", rd_data, m_q[0]); end
            step();
            cyc++;
        end
        checks++; if (cyc != 8 || fill !== 4'd0) begin
            errors++; $display("FAIL b2b_drain cycles=%0d fill=%0d exp 8/0", cyc, fill);
        end
        rd_ready = 0;
    endtask

    task automatic test_arm_abort();
        abort = 1; step();
        arm = 1; abort = 1; step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL arm_abort state=%0d exp 0", state); end
        trig_mode = 2'd0; post_cnt = 8'd4;
        arm = 1; step();
        for (int k = 0; k < 5; k++) instr(16'h0500 + 16'(k), 8'h11);
        if (m_rdv == 0) step();
        rd_ready = 1; step(); step(); rd_ready = 0;
        checks++; if (fill !== 4'd3 || state !== 2'd3) begin
            errors++; $display("FAIL rearm_pre fill=%0d state=%0d exp 3/3", fill, state);
        end
        arm = 1; step();
        checks++; if (fill !== 4'd0 || state !== 2'd1 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL rearm fill=%0d state=%0d rd_valid=%b exp 0/1/0", fill, state, rd_valid);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 150; c++) begin
                pc          = 16'h0200 + 16'($urandom_range(0, 7));
                ir          = 8'($urandom_range(0, 7));
                flags       = 4'($urandom);
                instr_valid = ($urandom_range(0, 2) != 0);
                rd_ready    = 1'($urandom_range(0, 1));
                trig_mode   = 2'($urandom_range(0, 3));
                trig_pc     = 16'h0200 + 16'($urandom_range(0, 7));
                trig_ir     = 8'($urandom_range(0, 7));
                post_cnt    = 8'($urandom_range(0, 12));
                arm         = ($urandom_range(0, 15) == 0) || (m_state == 0);
                abort       = ($urandom_range(0, 63) == 0);
                step();
                checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state got %0d exp %0d", state, m_state); end
                checks++; if (fill !== 4'(m_q.size())) begin errors++; $display("FAIL rnd_fill got %0d exp %0d", fill, m_q.size()); end
                checks++; if (triggered !== m_trig) begin errors++; $display("FAIL rnd_triggered got %b exp %b", triggered, m_trig); end
                checks++; if (rd_valid !== m_rdv) begin errors++; $display("FAIL rnd_rd_valid got %b exp %b", rd_valid, m_rdv); end
                if (m_rdv) begin
                    checks++; if (rd_data !== m_q[0]) begin errors++; $display("FAIL rnd_rd_data got %h exp %h", rd_data, m_q[0]); end
                end
            end
            abort = 1; step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_immediate();
        test_pc_match();
        test_ir_never();
        test_back_to_back();
        test_arm_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
